// File: rtl/div8x4_seq_pkg.sv
// Shared constants and FSM encoding for the sequential divider (and its
// multiplier companion bench).
package div8x4_seq_pkg;

  localparam int DIV_N = 8;
  localparam int DIV_M = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div8x4_seq_dp.sv
// Restoring-divider datapath: partial remainder P, quotient/dividend shift
// register Q, divisor D, and the M+1-bit trial subtractor with restore mux.
module div8x4_seq_dp #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [N-1:0] i_dividend,
  input  logic [M-1:0] i_divisor,
  output logic [N-1:0] o_q_next,
  output logic [M-1:0] o_r_next
);

  logic [M:0]   r_p;
  logic [N-1:0] r_q;
  logic [M-1:0] r_d;

  logic [M:0]   w_shifted;
  logic [M+1:0] w_diff;
  logic         w_borrow;
  logic [M:0]   w_p_next;
  logic [N-1:0] w_q_next;

  // Extra top bit of the difference is the borrow-out: set means shifted < D.
  assign w_shifted = {r_p[M-1:0], r_q[N-1]};
  assign w_diff    = {1'b0, w_shifted} - {2'b00, r_d};
  assign w_borrow  = w_diff[M+1];
  assign w_p_next  = w_borrow ? w_shifted : w_diff[M:0];
  assign w_q_next  = {r_q[N-2:0], ~w_borrow};

  assign o_q_next = w_q_next;
  assign o_r_next = w_p_next[M-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
      r_q <= '0;
      r_d <= '0;
    end else if (i_load) begin
      r_p <= '0;
      r_q <= i_dividend;
      r_d <= i_divisor;
    end else if (i_shift) begin
      r_p <= w_p_next;
      r_q <= w_q_next;
    end
  end

endmodule

// File: rtl/div8x4_seq.sv
// Sequential N/M restoring divider, one quotient bit per clock.
// Handshake: start is accepted only in IDLE; done pulses one cycle with results.
module div8x4_seq
  import div8x4_seq_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int M = DIV_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [1:0]   o_dbg_state
);

  localparam int CW = $clog2(N + 1);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_quotient;
  logic [M-1:0]  r_remainder;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;

  logic          w_load;
  logic          w_shift;
  logic [N-1:0]  w_q_next;
  logic [M-1:0]  w_r_next;

  assign w_load  = (r_state == ST_LOAD);
  assign w_shift = (r_state == ST_ITER);

  div8x4_seq_dp #(.N(N), .M(M)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_q_next   (w_q_next),
    .o_r_next   (w_r_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_count <= '0;
          if (divisor == '0) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_dbz       <= 1'b1;
            r_quotient  <= '1;
            r_remainder <= '0;
          end else begin
            r_state <= ST_ITER;
          end
        end
        ST_ITER: begin
          r_count <= r_count + 1'b1;
          // Results are taken from the final step's next values so they
          // line up with the done pulse.
          if (r_count == CW'(N - 1)) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div8x4_seq.sv
// Directed self-checking bench for div8x4_seq: hand-computed quotients,
// latency, handshake, abort and back-to-back operation.
module tb_div8x4_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [1:0] dbg_state;

  int n_cmp;
  int n_err;

  div8x4_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one start pulse at a negedge, then waits for done (bounded).
  // lat = number of rising edges after the accepting edge until done is seen.
  task automatic run_op(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                        input int exp_lat, input logic [7:0] exp_q,
                        input logic [3:0] exp_r, input logic exp_dbz);
    int lat;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_q"}, quotient, exp_q);
    chk({tag, "_r"}, remainder, exp_r);
    chk({tag, "_dbz"}, div_by_zero, exp_dbz);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 1'b0);
  endtask

  initial begin
    int lat;
    int n_done;
    int busy_drops;
    int last_done;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_state", dbg_state, 2'd0);
    chk("rst_q", quotient, 8'd0);
    chk("rst_r", remainder, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);

    run_op("d200_7", 8'd200, 4'd7, 9, 8'd28, 4'd4, 1'b0);
    repeat (4) @(negedge clk);
    chk("hold_q", quotient, 8'd28);
    chk("hold_r", remainder, 4'd4);

    run_op("d143_11", 8'd143, 4'd11, 9, 8'd13, 4'd0, 1'b0);
    run_op("d5_12",   8'd5,   4'd12, 9, 8'd0,  4'd5, 1'b0);
    run_op("d255_1",  8'd255, 4'd1,  9, 8'd255, 4'd0, 1'b0);
    run_op("d90_0",   8'd90,  4'd0,  1, 8'hFF, 4'd0, 1'b1);
    run_op("d90_9",   8'd90,  4'd9,  9, 8'd10, 4'd0, 1'b0);

    // Mid-operation restart attempt and operand change after LOAD.
    @(negedge clk);
    dividend = 8'd200;
    divisor = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 8'd13;
    divisor = 4'd13;
    lat = 1;
    n_done = 0;
    busy_drops = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      start = (lat == 5);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          chk("mid_lat", lat, 9);
          chk("mid_q", quotient, 8'd28);
          chk("mid_r", remainder, 4'd4);
        end
      end
      if (lat < 9 && !busy) busy_drops++;
    end
    start = 1'b0;
    chk("mid_ndone", n_done, 1);
    chk("mid_busy_drops", busy_drops, 0);

    // Reset in the middle of an operation aborts it silently.
    @(negedge clk);
    dividend = 8'd200;
    divisor = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_q", quotient, 8'd0);
    chk("abort_r", remainder, 4'd0);
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_ndone", n_done, 0);
    run_op("d13_13", 8'd13, 4'd13, 9, 8'd1, 4'd0, 1'b0);

    // Start held high: IDLE, LOAD, 8 ITER, DONE gives one result every 11 edges.
    @(negedge clk);
    dividend = 8'd100;
    divisor = 4'd3;
    start = 1'b1;
    n_done = 0;
    last_done = -1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 29) start = 1'b0;
      if (done) begin
        n_done++;
        chk("b2b_q", quotient, 8'd33);
        chk("b2b_r", remainder, 4'd1);
        if (last_done >= 0) chk("b2b_gap", c - last_done, 11);
        last_done = c;
      end
    end
    chk("b2b_ndone", n_done, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
